// File: rtl/pb_pkg.sv
// pb_pkg: shared constants, counter-width helper and per-channel event record for the push-button front end
package pb_pkg;
  localparam int PB_SYNC_STAGES_DEF = 2;
  localparam int PB_DB_CYCLES_DEF   = 16;
  localparam int PB_HOLD_CYCLES_DEF = 1024;
  typedef struct packed {
    logic level;
    logic pressed;
    logic released;
    logic held;
  } pb_evt_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pb_chan.sv
// pb_chan: one button channel (sync, debounce, press/release pulses, long-press pulse under PB_HOLD_EN)
module pb_chan import pb_pkg::*; #(
  parameter int SYNC_STAGES = PB_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = PB_DB_CYCLES_DEF,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_CYCLES = PB_HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic level_o,
  output logic pressed_o,
  output logic released_o,
  output logic held_o
);
  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic IDLE = logic'(ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pb_evt_t evt_q, evt_d;
  logic s, flip, accept, held_nxt;
  // xor with the idle level folds polarity so s is 1 while pressed
  assign s      = sync_q[SYNC_STAGES-1] ^ IDLE;
  assign flip   = s != evt_q.level;
  assign accept = flip && cnt_q == DB_LAST;
  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], pb_i};
    cnt_d          = (flip && !accept) ? cnt_q + CW'(1) : '0;
    evt_d.level    = accept ? s : evt_q.level;
    evt_d.pressed  = accept && s;
    evt_d.released = accept && !s;
    evt_d.held     = held_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      cnt_q  <= '0;
      evt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
    end
  end
`ifdef PB_HOLD_EN
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  logic [HW-1:0] hold_q, hold_d;
  // saturating at HOLD_MAX makes held fire once per press
  assign hold_d   = !evt_q.level ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
  assign held_nxt = evt_q.level && hold_q == HOLD_MAX - HW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign held_nxt = 1'b0 & (|HOLD_CYCLES);
`endif
  assign level_o    = evt_q.level;
  assign pressed_o  = evt_q.pressed;
  assign released_o = evt_q.released;
  assign held_o     = evt_q.held;
endmodule

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi: N_CH independent debounced push-button channels; long-press pulse enabled by PB_HOLD_EN
module pb_debounce_multi import pb_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = PB_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = PB_DB_CYCLES_DEF,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_CYCLES = PB_HOLD_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] held
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .pb_i      (pb[i]),
      .level_o   (level[i]),
      .pressed_o (pressed[i]),
      .released_o(released[i]),
      .held_o    (held[i])
    );
  end
endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb_pb_debounce_multi: directed vector table plus hand sequences for reset and long-press behaviour
module tb_pb_debounce_multi;
  typedef struct {
    logic [3:0] pb;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;
`ifdef PB_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pb = 4'hF;
  logic [3:0] level, pressed, released, held;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];

  pb_debounce_multi #(
    .N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(16), .ACTIVE_LOW(1), .HOLD_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .pb(pb),
    .level(level), .pressed(pressed), .released(released), .held(held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, id, act, exp);
    end
  endtask

  // drives pb for v.cyc edges; pulses must be absent until the final sampled cycle
  task automatic apply(input vec_t v, input int id);
    logic [3:0] noisy;
    noisy = '0;
    pb = v.pb;
    for (int k = 0; k < v.cyc; k++) begin
      @(negedge clk);
      if (k < v.cyc - 1) noisy |= pressed | released;
    end
    chk("level", id, level, v.lvl);
    chk("pressed", id, pressed, v.prs);
    chk("released", id, released, v.rel);
    chk("quiet", id, noisy, 4'h0);
  endtask

  initial begin
    tbl.push_back('{4'hF, 50, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'hE, 17, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'hE,  1, 4'h1, 4'h1, 4'h0});
    tbl.push_back('{4'hE,  1, 4'h1, 4'h0, 4'h0});
    for (int r = 0; r < 5; r++) begin
      tbl.push_back('{4'hF, 10, 4'h1, 4'h0, 4'h0});
      tbl.push_back('{4'hE, 10, 4'h1, 4'h0, 4'h0});
    end
    tbl.push_back('{4'hF, 17, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{4'hF,  1, 4'h0, 4'h0, 4'h1});
    tbl.push_back('{4'hF,  2, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5, 17, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{4'h5,  1, 4'hA, 4'hA, 4'h0});
    tbl.push_back('{4'h5,  1, 4'hA, 4'h0, 4'h0});
    tbl.push_back('{4'hF, 17, 4'hA, 4'h0, 4'h0});
    tbl.push_back('{4'hF,  1, 4'h0, 4'h0, 4'hA});
    tbl.push_back('{4'hF,  1, 4'h0, 4'h0, 4'h0});

    repeat (3) @(negedge clk);
    chk("rst_level", 0, level, 4'h0);
    chk("rst_pulses", 0, pressed | released | held, 4'h0);
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], i);

    apply('{4'hB, 18, 4'h4, 4'h4, 4'h0}, 100);
    apply('{4'hB,  2, 4'h4, 4'h0, 4'h0}, 101);
    #2 rst = 1'b1;
    #1 chk("async_rst_level", 102, level, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hold_level", 103, level, 4'h0);
    apply('{4'hB, 17, 4'h0, 4'h0, 4'h0}, 104);
    apply('{4'hB,  1, 4'h4, 4'h4, 4'h0}, 105);
    apply('{4'hB,  1, 4'h4, 4'h0, 4'h0}, 106);
    apply('{4'hF, 17, 4'h4, 4'h0, 4'h0}, 107);
    apply('{4'hF,  1, 4'h0, 4'h0, 4'h4}, 108);
    apply('{4'hF,  1, 4'h0, 4'h0, 4'h0}, 109);

    pb = 4'hE;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk("hold_pressed", k, pressed, {3'b000, k == 18});
      chk("hold_held", k, held, {3'b000, HOLD_ON && k == 18 + 32});
    end
    chk("hold_level", 200, level, 4'h1);
    chk("hold_released", 200, released, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
